// File: rtl/rf_writeback_scheduler_if.sv
// Writeback request/response bundle between the two requesters, the scheduler
// and the register-file write ports.
interface rf_writeback_scheduler_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Requester side: a request is taken on a cycle where valid and ready are both
  // high; ready is already qualified by valid, so ready alone means accepted.
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_dst;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [2:0]    b_dst_low;
  logic [2:0]    b_dst_high;
  logic [DW-1:0] b_data_low;
  logic [DW-1:0] b_data_high;

  // Register-file write ports and hazard/occupancy status.
  logic          reg_write_low;
  logic          reg_write_high;
  logic [2:0]    reg_dst_low;
  logic [2:0]    reg_dst_high;
  logic [DW-1:0] data_to_be_written_low;
  logic [DW-1:0] data_to_be_written_high;
  logic [7:0]    pending_mask;
  logic [CW-1:0] count;

  modport master (
    output a_valid, a_dst, a_data,
    output b_valid, b_dst_low, b_dst_high, b_data_low, b_data_high,
    input  a_ready, b_ready,
    input  reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
    input  data_to_be_written_low, data_to_be_written_high,
    input  pending_mask, count
  );

  modport slave (
    input  a_valid, a_dst, a_data,
    input  b_valid, b_dst_low, b_dst_high, b_data_low, b_data_high,
    output a_ready, b_ready,
    output reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
    output data_to_be_written_low, data_to_be_written_high,
    output pending_mask, count
  );
endinterface

// File: rtl/rf_writeback_scheduler.sv
// Arbitrates single (A) and paired (B) writeback requests into an in-order FIFO
// drained one entry per cycle onto registered register-file write ports.
module rf_writeback_scheduler #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  rf_writeback_scheduler_if.slave  wb,
  output logic                     rr_state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          pair;
    logic [2:0]    dst_low;
    logic [2:0]    dst_high;
    logic [DW-1:0] data_low;
    logic [DW-1:0] data_high;
  } entry_t;

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

  rr_e           rr_q, rr_d;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          reg_write_low_q, reg_write_high_q;
  logic [2:0]    reg_dst_low_q, reg_dst_high_q;
  logic [DW-1:0] data_low_q, data_high_q;

  logic          pop, push_ok, accept_ok, grant_a, grant_b, push;
  logic          a_ready, b_ready;
  entry_t        head, new_entry;
  logic [PW-1:0] off;
  logic [7:0]    mask;

  assign head = mem_q[rd_ptr_q];

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop       = (count_q != '0) && !flush;
  assign push_ok   = (count_q < CW'(DEPTH)) || pop;
  assign accept_ok = push_ok && !flush && !reset;
  assign grant_a   = wb.a_valid && (!wb.b_valid || (rr_q == RR_A));
  assign grant_b   = wb.b_valid && (!wb.a_valid || (rr_q == RR_B));
  assign a_ready   = grant_a && accept_ok;
  assign b_ready   = grant_b && accept_ok;
  assign push      = a_ready || b_ready;

  always_comb begin
    new_entry = '0;
    if (a_ready) begin
      new_entry.pair     = 1'b0;
      new_entry.dst_low  = wb.a_dst;
      new_entry.data_low = wb.a_data;
    end else begin
      new_entry.pair      = 1'b1;
      new_entry.dst_low   = wb.b_dst_low;
      new_entry.dst_high  = wb.b_dst_high;
      new_entry.data_low  = wb.b_data_low;
      new_entry.data_high = wb.b_data_high;
    end
  end

  // Round-robin pointer: after a grant the other port becomes preferred.
  always_comb begin
    rr_d = rr_q;
    if (a_ready)      rr_d = RR_B;
    else if (b_ready) rr_d = RR_A;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_A;
    else       rr_q <= rr_d;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      reg_write_low_q  <= 1'b0;
      reg_write_high_q <= 1'b0;
      reg_dst_low_q    <= '0;
      reg_dst_high_q   <= '0;
      data_low_q       <= '0;
      data_high_q      <= '0;
    end else if (flush) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      reg_write_low_q  <= 1'b0;
      reg_write_high_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q         <= rd_ptr_q + 1'b1;
        reg_write_low_q  <= 1'b1;
        // Same-register pair: only the low half is written.
        reg_write_high_q <= head.pair && (head.dst_low != head.dst_high);
        reg_dst_low_q    <= head.dst_low;
        reg_dst_high_q   <= head.dst_high;
        data_low_q       <= head.data_low;
        data_high_q      <= head.data_high;
      end else begin
        reg_write_low_q  <= 1'b0;
        reg_write_high_q <= 1'b0;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    mask = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        mask[mem_q[i].dst_low] = 1'b1;
        if (mem_q[i].pair) mask[mem_q[i].dst_high] = 1'b1;
      end
    end
    if (reg_write_low_q)  mask[reg_dst_low_q]  = 1'b1;
    if (reg_write_high_q) mask[reg_dst_high_q] = 1'b1;
  end

  assign wb.a_ready                 = a_ready;
  assign wb.b_ready                 = b_ready;
  assign wb.reg_write_low           = reg_write_low_q;
  assign wb.reg_write_high          = reg_write_high_q;
  assign wb.reg_dst_low             = reg_dst_low_q;
  assign wb.reg_dst_high            = reg_dst_high_q;
  assign wb.data_to_be_written_low  = data_low_q;
  assign wb.data_to_be_written_high = data_high_q;
  assign wb.pending_mask            = mask;
  assign wb.count                   = count_q;
  assign rr_state_o                 = rr_q;
endmodule
